mux8_scan_ctrl: RTL

//  Upstream sequencer for the 8:1 bit mux (data a..h, selects sel2:sel0, output out).
//  On start, steps the mux select through every enabled channel and waits a settle time per channel.

---
 rtl/mux8_pkg.sv | 16 +
 rtl/mux8_scan_ctrl_if.sv | 29 ++
 rtl/mux8_next_chan.sv | 31 +++
 rtl/mux8_scan_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/mux8_pkg.sv
// rtl/mux8_pkg.sv - shared constants and state type for the 8:1 mux scan controller
// Purpose: channel/select/counter widths and the scan FSM state encoding.
// Ports: none (package).
package mux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux8_scan_ctrl_if.sv
// rtl/mux8_scan_ctrl_if.sv - control, mux and result handshake bundle for mux8_scan_ctrl
// Purpose: groups the scan request, mux select/sample and result valid/ready signals.
// Signals: start, chan_mask[7:0], mux_out, res_ready (driven by master);
//          sel0/sel1/sel2, busy, res_word[7:0], res_valid (driven by slave = controller).
interface mux8_scan_ctrl_if;
    import mux8_pkg::*;

    logic              start;
    logic [NUM_CH-1:0] chan_mask;
    logic              mux_out;
    logic              sel0;
    logic              sel1;
    logic              sel2;
    logic              busy;
    logic [NUM_CH-1:0] res_word;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output start, chan_mask, mux_out, res_ready,
        input  sel0, sel1, sel2, busy, res_word, res_valid
    );

    modport slave (
        input  start, chan_mask, mux_out, res_ready,
        output sel0, sel1, sel2, busy, res_word, res_valid
    );

endinterface

// File: rtl/mux8_next_chan.sv
// rtl/mux8_next_chan.sv - lowest enabled channel at or above a given index
// Purpose: combinational search used for the first-channel pick and for advancing.
// Ports: mask[7:0] enabled channels, cur[2:0] lower bound, incl (1: >= cur, 0: > cur),
//        nxt[2:0] selected channel, found (a qualifying channel exists).
module mux8_next_chan
    import mux8_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              incl,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    logic [SEL_W-1:0] idx;

    // Scan from the top down so the lowest qualifying index is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = SEL_W'(i);
            if (mask[i] && ((idx > cur) || (incl && (idx == cur)))) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// rtl/mux8_scan_ctrl.sv - scans enabled 8:1 mux channels and returns a packed sample word
// Purpose: on start, selects each enabled channel in ascending order for SETTLE_CYCLES
//          cycles, samples mux_out at the last cycle, and offers the word over valid/ready.
// Ports: clk, rst (async, active high), bus (mux8_scan_ctrl_if.slave: start, chan_mask,
//        mux_out, res_ready in; sel0..sel2, busy, res_word, res_valid out).
// SETTLE_CYCLES must lie in 1..15 so the dwell count fits the 4-bit counter.
module mux8_scan_ctrl
    import mux8_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    mux8_scan_ctrl_if.slave  bus
);

    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] word_q, word_d;

    logic [SEL_W-1:0]  first_nxt, adv_nxt;
    logic              first_found, adv_found;

    // First pick looks at the live mask because it is being latched on the same edge.
    mux8_next_chan u_first (
        .mask  (bus.chan_mask),
        .cur   ('0),
        .incl  (1'b1),
        .nxt   (first_nxt),
        .found (first_found)
    );

    mux8_next_chan u_adv (
        .mask  (mask_q),
        .cur   (sel_q),
        .incl  (1'b0),
        .nxt   (adv_nxt),
        .found (adv_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        word_d  = word_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d = bus.chan_mask;
                    word_d = '0;
                    cnt_d  = '0;
                    if (first_found) begin
                        state_d = SCAN;
                        sel_d   = first_nxt;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    // Dwell end: capture this channel, then move on or finish.
                    word_d[sel_q] = bus.mux_out;
                    cnt_d         = '0;
                    if (adv_found) begin
                        sel_d = adv_nxt;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.sel0      = sel_q[0];
    assign bus.sel1      = sel_q[1];
    assign bus.sel2      = sel_q[2];
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_word  = word_q;

endmodule
